// File: rtl/fft_stage_sequencer.sv
// Butterfly/stage sequencer for an in-place radix-2 DIF FFT over shared real/imag RAMs.
// Optional bit-reversed unload pass is built when FFT_SEQ_BITREV_EN is defined.
module fft_stage_sequencer #(
  parameter int LOG2N = 6,
  parameter int AW    = LOG2N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          wr_sel,
  output logic          ld_a,
  output logic          ld_b,
  output logic [AW-2:0] tw_addr,
  output logic          bf_go,
  input  logic          bf_done,
  output logic [3:0]    stage,
  output logic          out_valid,
  output logic [AW-1:0] out_idx
);

  localparam int            HALF   = 1 << (LOG2N - 1);
  localparam logic [AW-2:0] B_LAST = (AW-1)'(HALF - 1);
  localparam logic [3:0]    S_LAST = 4'(LOG2N - 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RD_A   = 4'd1,
    ST_RD_B   = 4'd2,
    ST_LAUNCH = 4'd3,
    ST_WAIT   = 4'd4,
    ST_WR_A   = 4'd5,
    ST_WR_B   = 4'd6,
    ST_NEXT   = 4'd7,
`ifdef FFT_SEQ_BITREV_EN
    ST_UNLOAD = 4'd8,
`endif
    ST_DONE   = 4'd9
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [AW-2:0] b_reg;
  logic [3:0]    s_reg;
  logic [AW-2:0] tw_reg;

  // Per-stage address tables; the live stage picks one row.
  logic [AW-1:0] b_ext;
  logic [AW-1:0] n1_tab   [LOG2N];
  logic [AW-1:0] span_tab [LOG2N];
  logic [AW-2:0] tw_tab   [LOG2N];

  assign b_ext = {1'b0, b_reg};

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_stage
      localparam int            L    = LOG2N - 1 - gi;
      localparam logic [AW-1:0] SPAN = AW'(1) << L;
      logic [AW-1:0] j;
      assign j            = b_ext & (SPAN - AW'(1));
      // Insert a zero at bit L of b to form the upper-half-free index n1.
      assign n1_tab[gi]   = ((b_ext >> L) << (L + 1)) | j;
      assign span_tab[gi] = SPAN;
      assign tw_tab[gi]   = (AW-1)'(j << gi);
    end
  endgenerate

  logic [AW-1:0] n1;
  logic [AW-1:0] n2;
  logic [AW-1:0] span;
  logic [AW-2:0] tw_sel;

  always_comb begin
    n1     = '0;
    span   = '0;
    tw_sel = '0;
    for (int i = 0; i < LOG2N; i++) begin
      if (s_reg == 4'(i)) begin
        n1     = n1_tab[i];
        span   = span_tab[i];
        tw_sel = tw_tab[i];
      end
    end
  end

  assign n2 = n1 + span;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg  <= '0;
      b_reg  <= '0;
      tw_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            s_reg <= '0;
            b_reg <= '0;
          end
        end
        ST_RD_B: tw_reg <= tw_sel;
        ST_NEXT: begin
          if (b_reg != B_LAST) begin
            b_reg <= b_reg + 1'b1;
          end else if (s_reg != S_LAST) begin
            b_reg <= '0;
            s_reg <= s_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_SEQ_BITREV_EN
  localparam logic [AW:0] K_END = (AW+1)'(1 << LOG2N);

  logic [AW:0]   k_reg;
  logic [AW-1:0] k_rev;
  logic          out_valid_reg;
  logic [AW-1:0] out_idx_reg;

  generate
    for (gi = 0; gi < AW; gi++) begin : g_rev
      assign k_rev[gi] = k_reg[AW-1-gi];
    end
  endgenerate

  // k counts one past N so the final read's data gets its valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg         <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
    end else if (state_reg == ST_UNLOAD) begin
      k_reg         <= k_reg + 1'b1;
      out_valid_reg <= (k_reg != K_END);
      out_idx_reg   <= (k_reg != K_END) ? k_reg[AW-1:0] : '0;
    end else begin
      k_reg         <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_RD_A;
      ST_RD_A:   state_next = ST_RD_B;
      ST_RD_B:   state_next = ST_LAUNCH;
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT:   if (bf_done) state_next = ST_WR_A;
      ST_WR_A:   state_next = ST_WR_B;
      ST_WR_B:   state_next = ST_NEXT;
      ST_NEXT: begin
        if (b_reg != B_LAST || s_reg != S_LAST) begin
          state_next = ST_RD_A;
        end else begin
`ifdef FFT_SEQ_BITREV_EN
          state_next = ST_UNLOAD;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef FFT_SEQ_BITREV_EN
      ST_UNLOAD: if (k_reg == K_END) state_next = ST_DONE;
`endif
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != ST_IDLE);
    done      = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    wr_sel    = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    bf_go     = 1'b0;
    tw_addr   = tw_reg;
    stage     = s_reg;
`ifdef FFT_SEQ_BITREV_EN
    out_valid = out_valid_reg;
    out_idx   = out_idx_reg;
`else
    out_valid = 1'b0;
    out_idx   = '0;
`endif
    case (state_reg)
      ST_RD_A: ram_addr = n1;
      ST_RD_B: begin
        ram_addr = n2;
        ld_a     = 1'b1;
      end
      ST_LAUNCH: begin
        ld_b  = 1'b1;
        bf_go = 1'b1;
      end
      ST_WR_A: begin
        ram_addr = n1;
        ram_we   = 1'b1;
      end
      ST_WR_B: begin
        ram_addr = n2;
        ram_we   = 1'b1;
        wr_sel   = 1'b1;
      end
`ifdef FFT_SEQ_BITREV_EN
      ST_UNLOAD: if (k_reg != K_END) ram_addr = k_rev;
`endif
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: expected butterflies are queued at start
// and consumed as the DUT issues reads, launches and write-backs.
module tb_fft_stage_sequencer;
  localparam int LOG2N = 6;
  localparam int AW    = LOG2N;
  localparam int N     = 1 << LOG2N;
  localparam int HALF  = N / 2;
`ifdef FFT_SEQ_BITREV_EN
  localparam int BR = N + 1;
`else
  localparam int BR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          bf_done;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          wr_sel;
  logic          ld_a;
  logic          ld_b;
  logic [AW-2:0] tw_addr;
  logic          bf_go;
  logic [3:0]    stage;
  logic          out_valid;
  logic [AW-1:0] out_idx;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int n1;
    int n2;
    int tw;
    int s;
  } bfly_t;

  bfly_t sb[$];

  always #5 clk = ~clk;

  fft_stage_sequencer #(.LOG2N(LOG2N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_we(ram_we), .wr_sel(wr_sel), .ld_a(ld_a), .ld_b(ld_b),
    .tw_addr(tw_addr), .bf_go(bf_go), .bf_done(bf_done), .stage(stage),
    .out_valid(out_valid), .out_idx(out_idx)
  );

  task automatic push_expected();
    bfly_t e;
    int    span;
    sb.delete();
    for (int s = 0; s < LOG2N; s++) begin
      span = N >> (s + 1);
      for (int b = 0; b < HALF; b++) begin
        e.n1 = (b / span) * 2 * span + (b % span);
        e.n2 = e.n1 + span;
        e.tw = (b % span) * (1 << s);
        e.s  = s;
        sb.push_back(e);
      end
    end
  endtask

  function automatic int bitrev(input int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++)
      if ((k & (1 << i)) != 0) r = r | (1 << (LOG2N - 1 - i));
    return r;
  endfunction

  // mode 0: single start pulse; 1: extra start pulses while busy; 2: start held high.
  task automatic run_transform(input int delay, input int mode);
    bfly_t         e;
    int            cyc, exp_cyc, waitn, cnt, unl;
    logic          prev_go, prev_ov, want_sel;
    logic [AW-1:0] prev_addr;
    bit            waiting, busy_bad, ov_bad, finished, post_bad;
    push_expected();
    exp_cyc   = 1 + HALF * LOG2N * (7 + delay) + BR;
    start     = 1'b1;
    bf_done   = (delay == 0);
    cyc = 0; waitn = 0; cnt = 0; unl = 0;
    prev_go = 1'b0; prev_ov = 1'b0; want_sel = 1'b0; prev_addr = '0;
    waiting = 0; busy_bad = 0; ov_bad = 0; finished = 0;
    e = '{default: 0};
    while (!finished) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) busy_bad = 1;
      if (sb.size() > 0) e = sb[0];
      if (ld_a === 1'b1) begin
        checks++;
        if (sb.size() == 0 || prev_addr !== AW'(e.n1) || ram_addr !== AW'(e.n2)) begin
          errors++;
          $display("FAIL rd_addr cyc=%0d got n1=%0d n2=%0d want n1=%0d n2=%0d", cyc, prev_addr, ram_addr, e.n1, e.n2);
        end
      end
      if (bf_go === 1'b1) begin
        checks++;
        if (sb.size() == 0 || prev_go !== 1'b0 || ld_b !== 1'b1 || tw_addr !== (AW-1)'(e.tw) || stage !== 4'(e.s)) begin
          errors++;
          $display("FAIL launch cyc=%0d got tw=%0d stage=%0d ld_b=%b want tw=%0d stage=%0d ld_b=1", cyc, tw_addr, stage, ld_b, e.tw, e.s);
        end
        waiting = 1; waitn = 0; cnt = delay; want_sel = 1'b0;
      end else if (waiting && ram_we !== 1'b1) begin
        waitn++;
      end
      if (ram_we === 1'b1) begin
        if (waiting) begin
          checks++;
          if (waitn != delay + 1) begin
            errors++;
            $display("FAIL wait_len cyc=%0d got %0d want %0d", cyc, waitn, delay + 1);
          end
          waiting = 0;
        end
        checks++;
        if (sb.size() == 0 || wr_sel !== want_sel || ram_addr !== (want_sel ? AW'(e.n2) : AW'(e.n1))) begin
          errors++;
          $display("FAIL wr_addr cyc=%0d got addr=%0d sel=%b want addr=%0d sel=%b", cyc, ram_addr, wr_sel, want_sel ? e.n2 : e.n1, want_sel);
        end
        if (want_sel && sb.size() > 0) void'(sb.pop_front());
        want_sel = ~want_sel;
      end
`ifdef FFT_SEQ_BITREV_EN
      if (out_valid === 1'b1) begin
        checks++;
        if (out_idx !== AW'(unl) || prev_addr !== AW'(bitrev(unl)) || sb.size() != 0) begin
          errors++;
          $display("FAIL unload cyc=%0d got idx=%0d addr=%0d want idx=%0d addr=%0d", cyc, out_idx, prev_addr, unl, bitrev(unl));
        end
        unl++;
      end
`else
      if (out_valid !== 1'b0 || out_idx !== '0) ov_bad = 1;
`endif
      if (done === 1'b1) begin
        finished = 1;
        checks++;
        if (cyc != exp_cyc) begin
          errors++;
          $display("FAIL done_time got cycle %0d want %0d", cyc, exp_cyc);
        end
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL sb_left got %0d butterflies pending want 0", sb.size());
        end
`ifdef FFT_SEQ_BITREV_EN
        checks++;
        if (unl != N || prev_ov !== 1'b1) begin
          errors++;
          $display("FAIL unload_end got count=%0d last_valid=%b want count=%0d last_valid=1", unl, prev_ov, N);
        end
`endif
      end else if (cyc > exp_cyc + 100) begin
        checks++;
        errors++;
        $display("FAIL timeout got no done by cycle %0d want done at %0d", cyc, exp_cyc);
        finished = 1;
      end
      if (delay == 0)                        bf_done = 1'b1;
      else if (bf_go === 1'b1)               bf_done = 1'b1;
      else if (waiting && ram_we !== 1'b1) begin
        if (cnt == 0) bf_done = 1'b1;
        else begin bf_done = 1'b0; cnt--; end
      end else                               bf_done = 1'b0;
      case (mode)
        1:       start = (cyc == 100 || cyc == 900 || cyc == 1200);
        2:       start = 1'b1;
        default: start = 1'b0;
      endcase
      prev_go   = bf_go;
      prev_addr = ram_addr;
      prev_ov   = out_valid;
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL busy_gap got busy=0 during transform want 1");
    end
`ifndef FFT_SEQ_BITREV_EN
    checks++;
    if (ov_bad) begin
      errors++;
      $display("FAIL out_tied got out_valid/out_idx nonzero want 0");
    end
`endif
    $display("transform delay=%0d mode=%0d done at cycle %0d", delay, mode, cyc);
    if (mode != 2) begin
      start = 1'b0; bf_done = 1'b0; post_bad = 0;
      repeat (5) begin
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) post_bad = 1;
      end
      checks++;
      if (post_bad) begin
        errors++;
        $display("FAIL post_done got activity after done want idle");
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bf_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, ram_we, wr_sel, ld_a, ld_b, bf_go, out_valid} !== 8'b0 ||
          ram_addr !== '0 || tw_addr !== '0 || stage !== 4'd0 || out_idx !== '0) begin
        errors++;
        $display("FAIL reset cyc=%0d got busy=%b done=%b we=%b addr=%0d stage=%0d want all 0", i, busy, done, ram_we, ram_addr, stage);
      end
    end
  endtask

  task automatic test_basic();
    run_transform(0, 0);
  endtask

  task automatic test_slow_done();
    run_transform(3, 0);
  endtask

  task automatic test_start_ignored();
    run_transform(0, 1);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit extra;
    run_transform(0, 2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ram_addr !== '0 || stage !== 4'd0) begin
      errors++;
      $display("FAIL b2b_relaunch got busy=%b addr=%0d stage=%0d want 1 0 0", busy, ram_addr, stage);
    end
    start = 1'b0;
    cyc = 1;
    while (cyc < 1 + HALF * LOG2N * 7 + BR + 100) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) break;
    end
    checks++;
    if (done !== 1'b1 || cyc != 1 + HALF * LOG2N * 7 + BR) begin
      errors++;
      $display("FAIL b2b_done got done=%b at cycle %0d want 1 at %0d", done, cyc, 1 + HALF * LOG2N * 7 + BR);
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra = 1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL b2b_extra got extra done/busy want none");
    end
    bf_done = 1'b0;
  endtask

  task automatic test_reset_abort();
    int  cyc, seen;
    bit  bad;
    start = 1'b1; bf_done = 1'b1; cyc = 0; seen = 0;
    while (seen < 60 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (stage === 4'd3) seen++;
    end
    checks++;
    if (seen < 60) begin
      errors++;
      $display("FAIL abort_reach got %0d cycles in stage 3 want 60", seen);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || done !== 1'b0 || stage !== 4'd0 || ram_addr !== '0) begin
      errors++;
      $display("FAIL abort_state got busy=%b we=%b done=%b stage=%0d addr=%0d want 0", busy, ram_we, done, stage, ram_addr);
    end
    rst = 1'b0; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || ram_we !== 1'b0 || done !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_quiet got activity after reset want none");
    end
    run_transform(0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bf_done = 1'b0;
    test_reset();
    test_basic();
    test_slow_done();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
